acc_offload_adapter: RTL and testbench

Core-side offload stage that sits between a core's adapter-bus port and the accelerator request/response bus (ACC_BUS). Each offered instruction is broadcast to NumAcc combinational predecoders. The block picks the accepting accelerator, waits for the required source operands, and acknowledges the core. It then registers the request onto the accelerator bus with a target address and a transaction id, and tracks outstanding writebacks for back-pressure.

---
 rtl/acc_offload_adapter.sv | 157 +++++++++++++++
 tb/tb_acc_offload_adapter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_offload_adapter.sv
// Core-side accelerator offload stage: predecoder arbitration, operand and
// credit gating, registered request issue, and response pass-through.
module acc_offload_adapter #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumAcc         = 4,
  parameter int unsigned AddrWidth      = (NumAcc > 1) ? $clog2(NumAcc) : 1,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            core_q_instr_data_i,
  input  logic [DataWidth-1:0]   core_q_rs1_i,
  input  logic [DataWidth-1:0]   core_q_rs2_i,
  input  logic [DataWidth-1:0]   core_q_rs3_i,
  input  logic [2:0]             core_q_rs_valid_i,
  input  logic                   core_q_valid_i,
  output logic                   core_q_ready_o,
  output logic                   core_k_accept_o,
  output logic [1:0]             core_k_writeback_o,
  output logic [DataWidth-1:0]   core_p_data0_o,
  output logic [DataWidth-1:0]   core_p_data1_o,
  output logic                   core_p_dual_writeback_o,
  output logic [4:0]             core_p_rd_o,
  output logic                   core_p_error_o,
  output logic                   core_p_valid_o,
  input  logic                   core_p_ready_i,
  output logic [31:0]            pd_instr_data_o,
  input  logic [NumAcc-1:0]      pd_accept_i,
  input  logic [2*NumAcc-1:0]    pd_writeback_i,
  input  logic [3*NumAcc-1:0]    pd_use_rs_i,
  output logic [AddrWidth-1:0]   acc_q_addr_o,
  output logic [31:0]            acc_q_data_op_o,
  output logic [DataWidth-1:0]   acc_q_data_arga_o,
  output logic [DataWidth-1:0]   acc_q_data_argb_o,
  output logic [DataWidth-1:0]   acc_q_data_argc_o,
  output logic [IdWidth-1:0]     acc_q_id_o,
  output logic                   acc_q_valid_o,
  input  logic                   acc_q_ready_i,
  input  logic [DataWidth-1:0]   acc_p_data0_i,
  input  logic [DataWidth-1:0]   acc_p_data1_i,
  input  logic                   acc_p_dual_writeback_i,
  input  logic [IdWidth-1:0]     acc_p_id_i,
  input  logic [4:0]             acc_p_rd_i,
  input  logic                   acc_p_error_i,
  input  logic                   acc_p_valid_i,
  output logic                   acc_p_ready_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [AddrWidth-1:0] sel;
  logic [2:0]           use_sel;
  logic [1:0]           wb_sel;
  logic                 found;
  logic                 any_acc, ops_ok, slot_free, credit_ok;
  logic                 accept_hs, reject;
  logic                 inc, dec;

  logic                 aq_valid_q;
  logic [AddrWidth-1:0] aq_addr_q;
  logic [31:0]          aq_op_q;
  logic [DataWidth-1:0] aq_a_q, aq_b_q, aq_c_q;
  logic [IdWidth-1:0]   aq_id_q;
  logic [IdWidth-1:0]   id_q;
  logic [CntW-1:0]      outst_q, outst_d;

  // Response id is carried by the bus but never inspected here.
  logic unused_id;
  assign unused_id = ^acc_p_id_i;

  assign pd_instr_data_o = core_q_instr_data_i;

  // Priority pick of the lowest-index accepting predecoder and its attributes.
  always_comb begin
    sel     = '0;
    use_sel = '0;
    wb_sel  = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NumAcc; i++) begin
      if (!found && pd_accept_i[i]) begin
        found   = 1'b1;
        sel     = AddrWidth'(i);
        use_sel = pd_use_rs_i[3*i +: 3];
        wb_sel  = pd_writeback_i[2*i +: 2];
      end
    end
  end

  assign any_acc   = |pd_accept_i;
  assign ops_ok    = (use_sel & ~core_q_rs_valid_i) == 3'b000;
  assign slot_free = !aq_valid_q || acc_q_ready_i;
  assign credit_ok = (wb_sel == 2'b00) || (outst_q < CntW'(MaxOutstanding));
  assign accept_hs = !rst_i && core_q_valid_i && any_acc && ops_ok && slot_free && credit_ok;
  assign reject    = !rst_i && core_q_valid_i && !any_acc;

  assign core_q_ready_o     = accept_hs || reject;
  assign core_k_accept_o    = accept_hs;
  assign core_k_writeback_o = accept_hs ? wb_sel : 2'b00;

  assign core_p_data0_o          = acc_p_data0_i;
  assign core_p_data1_o          = acc_p_data1_i;
  assign core_p_dual_writeback_o = acc_p_dual_writeback_i;
  assign core_p_rd_o             = acc_p_rd_i;
  assign core_p_error_o          = acc_p_error_i;
  assign core_p_valid_o          = acc_p_valid_i;
  assign acc_p_ready_o           = core_p_ready_i;

  assign acc_q_valid_o     = aq_valid_q;
  assign acc_q_addr_o      = aq_addr_q;
  assign acc_q_data_op_o   = aq_op_q;
  assign acc_q_data_arga_o = aq_a_q;
  assign acc_q_data_argb_o = aq_b_q;
  assign acc_q_data_argc_o = aq_c_q;
  assign acc_q_id_o        = aq_id_q;

  // Request register: reload on accept takes priority over drain, giving 1 req/cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aq_valid_q <= 1'b0;
      aq_addr_q  <= '0;
      aq_op_q    <= '0;
      aq_a_q     <= '0;
      aq_b_q     <= '0;
      aq_c_q     <= '0;
      aq_id_q    <= '0;
      id_q       <= '0;
    end else if (accept_hs) begin
      aq_valid_q <= 1'b1;
      aq_addr_q  <= sel;
      aq_op_q    <= core_q_instr_data_i;
      aq_a_q     <= core_q_rs1_i;
      aq_b_q     <= core_q_rs2_i;
      aq_c_q     <= core_q_rs3_i;
      aq_id_q    <= id_q;
      id_q       <= id_q + IdWidth'(1);
    end else if (acc_q_ready_i) begin
      aq_valid_q <= 1'b0;
    end
  end

  // Outstanding writeback count: issue adds, core response handshake removes.
  always_comb begin
    inc     = accept_hs && (wb_sel != 2'b00);
    dec     = core_p_valid_o && core_p_ready_i && (outst_q != '0);
    outst_d = outst_q;
    if (inc && !dec)      outst_d = outst_q + CntW'(1);
    else if (dec && !inc) outst_d = outst_q - CntW'(1);
  end

  // Outstanding counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) outst_q <= '0;
    else       outst_q <= outst_d;
  end

endmodule

// File: tb/tb_acc_offload_adapter.sv
// Scoreboard bench for acc_offload_adapter: directed offers push expected
// requests; a monitor pops and compares on every acc_q handshake.
module tb_acc_offload_adapter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] core_q_instr_data_i, core_q_rs1_i, core_q_rs2_i, core_q_rs3_i;
  logic [2:0]  core_q_rs_valid_i;
  logic        core_q_valid_i, core_q_ready_o, core_k_accept_o;
  logic [1:0]  core_k_writeback_o;
  logic [31:0] core_p_data0_o, core_p_data1_o;
  logic        core_p_dual_writeback_o, core_p_error_o, core_p_valid_o, core_p_ready_i;
  logic [4:0]  core_p_rd_o;
  logic [31:0] pd_instr_data_o;
  logic [3:0]  pd_accept_i;
  logic [7:0]  pd_writeback_i;
  logic [11:0] pd_use_rs_i;
  logic [1:0]  acc_q_addr_o;
  logic [31:0] acc_q_data_op_o, acc_q_data_arga_o, acc_q_data_argb_o, acc_q_data_argc_o;
  logic [3:0]  acc_q_id_o;
  logic        acc_q_valid_o, acc_q_ready_i;
  logic [31:0] acc_p_data0_i, acc_p_data1_i;
  logic        acc_p_dual_writeback_i, acc_p_error_i, acc_p_valid_i, acc_p_ready_o;
  logic [3:0]  acc_p_id_i;
  logic [4:0]  acc_p_rd_i;

  always #5 clk_i = ~clk_i;

  acc_offload_adapter #(.DataWidth(32), .NumAcc(4), .IdWidth(4), .MaxOutstanding(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_q_instr_data_i(core_q_instr_data_i), .core_q_rs1_i(core_q_rs1_i),
    .core_q_rs2_i(core_q_rs2_i), .core_q_rs3_i(core_q_rs3_i),
    .core_q_rs_valid_i(core_q_rs_valid_i), .core_q_valid_i(core_q_valid_i),
    .core_q_ready_o(core_q_ready_o), .core_k_accept_o(core_k_accept_o),
    .core_k_writeback_o(core_k_writeback_o),
    .core_p_data0_o(core_p_data0_o), .core_p_data1_o(core_p_data1_o),
    .core_p_dual_writeback_o(core_p_dual_writeback_o), .core_p_rd_o(core_p_rd_o),
    .core_p_error_o(core_p_error_o), .core_p_valid_o(core_p_valid_o),
    .core_p_ready_i(core_p_ready_i),
    .pd_instr_data_o(pd_instr_data_o), .pd_accept_i(pd_accept_i),
    .pd_writeback_i(pd_writeback_i), .pd_use_rs_i(pd_use_rs_i),
    .acc_q_addr_o(acc_q_addr_o), .acc_q_data_op_o(acc_q_data_op_o),
    .acc_q_data_arga_o(acc_q_data_arga_o), .acc_q_data_argb_o(acc_q_data_argb_o),
    .acc_q_data_argc_o(acc_q_data_argc_o), .acc_q_id_o(acc_q_id_o),
    .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
    .acc_p_data0_i(acc_p_data0_i), .acc_p_data1_i(acc_p_data1_i),
    .acc_p_dual_writeback_i(acc_p_dual_writeback_i), .acc_p_id_i(acc_p_id_i),
    .acc_p_rd_i(acc_p_rd_i), .acc_p_error_i(acc_p_error_i),
    .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o)
  );

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] op, a, b, c;
    logic [3:0]  id;
  } txn_t;

  txn_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [3:0]  exp_id = 4'd0;
  logic [23:0] serial = 24'd0;
  logic [31:0] last_op = 32'd0;
  logic        aq_rdy = 1'b1, pv = 1'b0, pr = 1'b0;

  localparam logic [31:0] K1 = 32'h1111_1111;
  localparam logic [31:0] K2 = 32'h2222_2222;
  localparam logic [31:0] K3 = 32'h3333_3333;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus plus the expected core-side handshake outputs.
  task automatic cyc(input bit v, input logic [3:0] acc, input logic [2:0] rsv,
                     input bit e_rdy, input bit e_acc, input logic [1:0] e_wb,
                     input logic [1:0] e_addr, input bit push);
    logic [31:0] op;
    @(negedge clk_i);
    serial = serial + 24'd1;
    op = {8'hA5, serial};
    acc_q_ready_i       = aq_rdy;
    acc_p_valid_i       = pv;
    core_p_ready_i      = pr;
    core_q_valid_i      = v;
    core_q_instr_data_i = op;
    core_q_rs1_i        = op ^ K1;
    core_q_rs2_i        = op ^ K2;
    core_q_rs3_i        = op ^ K3;
    core_q_rs_valid_i   = rsv;
    pd_accept_i         = acc;
    #1;
    chk("q_ready", core_q_ready_o, e_rdy);
    chk("k_accept", core_k_accept_o, e_acc);
    chk("k_writeback", core_k_writeback_o, e_wb);
    chk("pd_instr", pd_instr_data_o, op);
    if (e_acc) begin
      if (push) sb.push_back('{e_addr, op, op ^ K1, op ^ K2, op ^ K3, exp_id});
      exp_id  = exp_id + 4'd1;
      last_op = op;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
  endtask

  // Monitor: every request handshake must match the head of the scoreboard.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk_i);
      #3;
      if (!rst_i && acc_q_valid_o && acc_q_ready_i) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_issue", 32'd1, 32'd0);
        end else begin
          t = sb.pop_front();
          chk("aq_addr", acc_q_addr_o, t.addr);
          chk("aq_id", acc_q_id_o, t.id);
          chk("aq_op", acc_q_data_op_o, t.op);
          chk("aq_arga", acc_q_data_arga_o, t.a);
          chk("aq_argb", acc_q_data_argb_o, t.b);
          chk("aq_argc", acc_q_data_argc_o, t.c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    // lane0: wb00 use111, lane1: wb01 use011, lane2: wb10 use111, lane3: wb00 use000
    pd_writeback_i = {2'b00, 2'b10, 2'b01, 2'b00};
    pd_use_rs_i    = {3'b000, 3'b111, 3'b011, 3'b111};
    rst_i = 1'b1;
    core_q_valid_i = 1'b0; core_q_instr_data_i = '0; core_q_rs_valid_i = '0;
    core_q_rs1_i = '0; core_q_rs2_i = '0; core_q_rs3_i = '0;
    pd_accept_i = '0; acc_q_ready_i = 1'b0; core_p_ready_i = 1'b0;
    acc_p_valid_i = 1'b0; acc_p_data0_i = '0; acc_p_data1_i = '0;
    acc_p_dual_writeback_i = 1'b0; acc_p_id_i = '0; acc_p_rd_i = '0; acc_p_error_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state
    idle();
    chk("rst_aq_valid", acc_q_valid_o, 0);
    chk("rst_aq_addr", acc_q_addr_o, 0);
    chk("rst_aq_op", acc_q_data_op_o, 0);
    chk("rst_aq_id", acc_q_id_o, 0);

    // First accept: lanes 1,2 accept -> lane 1 wins (wb01, id0); outstanding=1
    cyc(1, 4'b0110, 3'b011, 1, 1, 2'b01, 2'd1, 1);
    idle();
    chk("first_aq_valid", acc_q_valid_o, 1);

    // Operand wait on lane 0 (use 111)
    repeat (3) cyc(1, 4'b0001, 3'b011, 0, 0, 2'b00, 2'd0, 1);
    cyc(1, 4'b0001, 3'b111, 1, 1, 2'b00, 2'd0, 1);

    // Reject: nobody accepts
    cyc(1, 4'b0000, 3'b111, 1, 0, 2'b00, 2'd0, 1);
    idle();
    chk("reject_no_issue", acc_q_valid_o, 0);

    // Back-pressure: held request must stay stable and block new offers
    aq_rdy = 1'b0;
    cyc(1, 4'b1000, 3'b000, 1, 1, 2'b00, 2'd3, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 4'b0001, 3'b111, 0, 0, 2'b00, 2'd0, 1);
      chk("bp_valid", acc_q_valid_o, 1);
      chk("bp_addr", acc_q_addr_o, 3);
      chk("bp_id", acc_q_id_o, 2);
      chk("bp_op", acc_q_data_op_o, last_op);
    end
    // Full throughput, ids 3..15 then wrap to 0,1
    aq_rdy = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k % 2 == 1) cyc(1, 4'b1000, 3'b000, 1, 1, 2'b00, 2'd3, 1);
      else            cyc(1, 4'b0001, 3'b111, 1, 1, 2'b00, 2'd0, 1);
    end
    idle();

    // Response pass-through, core not ready
    pv = 1'b1; pr = 1'b0;
    acc_p_rd_i = 5'd7; acc_p_data0_i = 32'hCAFE_0001; acc_p_data1_i = 32'hBEEF_0002;
    acc_p_dual_writeback_i = 1'b1; acc_p_error_i = 1'b1; acc_p_id_i = 4'd9;
    idle();
    chk("p_valid", core_p_valid_o, 1);
    chk("p_ready_back", acc_p_ready_o, 0);
    chk("p_rd", core_p_rd_o, 7);
    chk("p_data0", core_p_data0_o, 32'hCAFE_0001);
    chk("p_data1", core_p_data1_o, 32'hBEEF_0002);
    chk("p_dual", core_p_dual_writeback_o, 1);
    chk("p_error", core_p_error_o, 1);
    pr = 1'b1;
    idle();
    chk("p_ready_fwd", acc_p_ready_o, 1);   // outstanding 1 -> 0
    pv = 1'b0; pr = 1'b0;

    // Credit limit: 4 writeback issues, 5th stalls, wb=0 still goes
    cyc(1, 4'b0010, 3'b111, 1, 1, 2'b01, 2'd1, 1);
    cyc(1, 4'b0010, 3'b111, 1, 1, 2'b01, 2'd1, 1);
    cyc(1, 4'b0100, 3'b111, 1, 1, 2'b10, 2'd2, 1);
    cyc(1, 4'b0100, 3'b111, 1, 1, 2'b10, 2'd2, 1);
    cyc(1, 4'b0100, 3'b111, 0, 0, 2'b00, 2'd0, 1);
    cyc(1, 4'b1000, 3'b000, 1, 1, 2'b00, 2'd3, 1);
    pv = 1'b1; pr = 1'b1;
    idle();                                   // 4 -> 3
    pv = 1'b0; pr = 1'b0;
    cyc(1, 4'b0100, 3'b111, 1, 1, 2'b10, 2'd2, 1);   // 3 -> 4
    pv = 1'b1; pr = 1'b1;
    idle();                                   // 4 -> 3
    cyc(1, 4'b0010, 3'b111, 1, 1, 2'b01, 2'd1, 1);   // issue + response: stays 3
    pv = 1'b0; pr = 1'b0;
    cyc(1, 4'b0010, 3'b111, 1, 1, 2'b01, 2'd1, 1);   // 3 -> 4
    cyc(1, 4'b0010, 3'b111, 0, 0, 2'b00, 2'd0, 1);   // full

    // Drain with extra responses; counter must floor at 0
    pv = 1'b1; pr = 1'b1;
    repeat (6) idle();
    pv = 1'b0; pr = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1, 4'b0100, 3'b111, 1, 1, 2'b10, 2'd2, 1);
    cyc(1, 4'b0100, 3'b111, 0, 0, 2'b00, 2'd0, 1);

    // Reset mid-operation: held request dropped, id and outstanding cleared
    aq_rdy = 1'b0;
    cyc(1, 4'b1000, 3'b000, 1, 1, 2'b00, 2'd3, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    core_q_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_id = 4'd0;
    aq_rdy = 1'b1;
    idle();
    chk("rst_mid_discard", acc_q_valid_o, 0);
    for (int k = 0; k < 4; k++) cyc(1, 4'b0010, 3'b111, 1, 1, 2'b01, 2'd1, 1);
    cyc(1, 4'b0010, 3'b111, 0, 0, 2'b00, 2'd0, 1);

    repeat (3) idle();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
